// File: rtl/vga_wr_arbiter_if.sv
// Write-port bundle between the pixel requesters and the frame BRAM arbiter.
// master = requester/BRAM side, slave = the arbiter itself.
interface vga_wr_arbiter_if #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   bram_we;
  logic [ADDR_W-1:0]      bram_addr;
  logic [DATA_W-1:0]      bram_din;

  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready, bram_we, bram_addr, bram_din
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/vga_wr_arbiter.sv
// Round-robin arbiter with burst lock, address range filter and lock watchdog
// for the single write port of the 640x480 8-bit VGA frame BRAM.
module vga_wr_arbiter #(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_ADDR = 307199,
  parameter int unsigned LOCK_TO  = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vga_wr_arbiter_if.slave       bus,
  output logic                  busy,
  output logic [7:0]            drop_cnt,
  output logic                  lock_err
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WD_W  = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;
  localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(LOCK_TO - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  owner_q;
  logic [IDX_W-1:0]  rr_q;
  logic [NREQ-1:0]   gnt_q;
  logic [WD_W-1:0]   wd_q;
  logic              busy_q;
  logic              lock_err_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [7:0]        drop_q;

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  // First valid requester at or after start, wrapping.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] idx;
    logic             found;
    res   = start;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDX_W'((32'(start) + k) % NREQ);
      if (!found && v[idx]) begin
        found = 1'b1;
        res   = idx;
      end
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  logic             owner_valid;
  logic             owner_lock;
  logic             accept;
  logic             any_valid;
  logic             wd_expire;
  logic             do_release;
  logic [IDX_W-1:0] owner_nxt;
  logic [IDX_W-1:0] pick_rr;
  logic [IDX_W-1:0] pick_nxt;

  // Arbitration decode for the current cycle.
  always_comb begin
    owner_valid = bus.req_valid[owner_q];
    owner_lock  = bus.req_lock[owner_q];
    accept      = (state_q != S_IDLE) && owner_valid;
    any_valid   = |bus.req_valid;
    owner_nxt   = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
    pick_rr     = rr_pick(bus.req_valid, rr_q);
    pick_nxt    = rr_pick(bus.req_valid, owner_nxt);
    wd_expire   = (state_q == S_LOCK) && !owner_valid && (wd_q == WD_LAST);
    do_release  = 1'b0;
    case (state_q)
      S_OWN:   do_release = !(accept && owner_lock);
      S_LOCK:  do_release = (accept && !owner_lock) || wd_expire;
      default: do_release = 1'b0;
    endcase
  end

  // Grant FSM: release hands over from owner+1 with the owner considered last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      gnt_q      <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      lock_err_q <= 1'b0;
    end else if (do_release) begin
      rr_q <= owner_nxt;
      wd_q <= '0;
      if (wd_expire) lock_err_q <= 1'b1;
      if (any_valid) begin
        owner_q <= pick_nxt;
        gnt_q   <= onehot(pick_nxt);
        state_q <= S_OWN;
        busy_q  <= 1'b1;
      end else begin
        gnt_q   <= '0;
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            owner_q <= pick_rr;
            gnt_q   <= onehot(pick_rr);
            state_q <= S_OWN;
            busy_q  <= 1'b1;
          end
        end
        S_OWN: begin
          state_q <= S_LOCK;
          wd_q    <= '0;
        end
        S_LOCK: begin
          if (accept) wd_q <= '0;
          else        wd_q <= wd_q + WD_W'(1);
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write register: one cycle after accept; out-of-range beats are swallowed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      drop_q <= '0;
    end else if (accept) begin
      if (addr_arr[owner_q] <= MAX_A) begin
        we_q   <= 1'b1;
        addr_q <= addr_arr[owner_q];
        din_q  <= data_arr[owner_q];
      end else begin
        we_q <= 1'b0;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end else begin
      we_q <= 1'b0;
    end
  end

  assign bus.req_ready = gnt_q;
  assign bus.bram_we   = we_q;
  assign bus.bram_addr = addr_q;
  assign bus.bram_din  = din_q;
  assign busy          = busy_q;
  assign drop_cnt      = drop_q;
  assign lock_err      = lock_err_q;

endmodule

// File: tb/tb_vga_wr_arbiter.sv
// Directed bench for vga_wr_arbiter: round-robin, burst lock, range filter,
// idle owner hand-over, lock watchdog and asynchronous reset mid-burst.
module tb_vga_wr_arbiter;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;

  logic       clk;
  logic       reset_n;
  logic       busy;
  logic [7:0] drop_cnt;
  logic       lock_err;

  int n_chk  = 0;
  int n_fail = 0;

  vga_wr_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_wr_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ADDR(307199), .LOCK_TO(1024)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt),
    .lock_err (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_valid[i]                   = v;
    bus.req_lock[i]                    = l;
    bus.req_addr[i*ADDR_W +: ADDR_W]   = a;
    bus.req_data[i*DATA_W +: DATA_W]   = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  task automatic apply_reset();
    clear_reqs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_reqs();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL rst_ready: got %b expected 000", bus.req_ready); end
    n_chk++; if (bus.bram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b expected 0", bus.bram_we); end
    n_chk++; if (bus.bram_addr !== 19'd0) begin n_fail++; $display("FAIL rst_addr: got %0d expected 0", bus.bram_addr); end
    n_chk++; if (bus.bram_din !== 8'd0) begin n_fail++; $display("FAIL rst_din: got %0h expected 0", bus.bram_din); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop: got %0d expected 0", drop_cnt); end
    n_chk++; if (lock_err !== 1'b0) begin n_fail++; $display("FAIL rst_lockerr: got %b expected 0", lock_err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [ADDR_W-1:0] exp_addr [5];
    exp_addr[0] = 19'd10; exp_addr[1] = 19'd20; exp_addr[2] = 19'd30;
    exp_addr[3] = 19'd10; exp_addr[4] = 19'd20;
    apply_reset();
    set_req(0, 1'b1, 1'b0, 19'd10, 8'hA0);
    set_req(1, 1'b1, 1'b0, 19'd20, 8'hA1);
    set_req(2, 1'b1, 1'b0, 19'd30, 8'hA2);
    tick();
    n_chk++; if (bus.bram_we !== 1'b0) begin n_fail++; $display("FAIL rr_we_early: got %b expected 0", bus.bram_we); end
    n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL rr_first_grant: got %b expected 001", bus.req_ready); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++;
      if (bus.bram_we !== 1'b1 || bus.bram_addr !== exp_addr[k]) begin
        n_fail++;
        $display("FAIL rr_write%0d: got we=%b addr=%0d expected we=1 addr=%0d", k, bus.bram_we, bus.bram_addr, exp_addr[k]);
      end
    end
    n_chk++; if (bus.bram_din !== 8'hA1) begin n_fail++; $display("FAIL rr_din: got %0h expected a1", bus.bram_din); end
    clear_reqs();
    tick();
    n_chk++; if (bus.bram_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got we=%b busy=%b expected 0/0", bus.bram_we, busy); end
  endtask

  task automatic test_burst_lock();
    int burst_bad;
    burst_bad = 0;
    apply_reset();
    set_req(1, 1'b1, 1'b0, 19'd5000, 8'h11);
    set_req(0, 1'b1, 1'b1, 19'd0, 8'h00);
    tick();
    n_chk++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL burst_grant: got %b expected 001", bus.req_ready); end
    for (int b = 0; b < 640; b++) begin
      set_req(0, 1'b1, (b != 639), 19'(b), 8'(b));
      tick();
      if (bus.bram_we !== 1'b1 || bus.bram_addr !== 19'(b) || bus.bram_din !== 8'(b)) burst_bad++;
      if (b < 639 && bus.req_ready !== 3'b001) burst_bad++;
    end
    n_chk++; if (burst_bad !== 0) begin n_fail++; $display("FAIL burst_contig: got %0d bad beats expected 0", burst_bad); end
    n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL burst_handover: got %b expected 010", bus.req_ready); end
    set_req(0, 1'b0, 1'b0, 19'd0, 8'h00);
    tick();
    n_chk++; if (bus.bram_we !== 1'b1 || bus.bram_addr !== 19'd5000) begin n_fail++; $display("FAIL burst_req1: got we=%b addr=%0d expected we=1 addr=5000", bus.bram_we, bus.bram_addr); end
    set_req(1, 1'b0, 1'b0, 19'd5000, 8'h11);
    tick();
    tick();
    n_chk++; if (bus.bram_we !== 1'b0 || bus.bram_addr !== 19'd5000) begin n_fail++; $display("FAIL burst_hold: got we=%b addr=%0d expected we=0 addr=5000", bus.bram_we, bus.bram_addr); end
  endtask

  task automatic test_range();
    int range_bad;
    range_bad = 0;
    apply_reset();
    set_req(1, 1'b1, 1'b0, 19'd307200, 8'hAA);
    tick();
    tick();
    n_chk++; if (bus.bram_we !== 1'b0 || drop_cnt !== 8'd1) begin n_fail++; $display("FAIL range_drop: got we=%b drop=%0d expected we=0 drop=1", bus.bram_we, drop_cnt); end
    set_req(1, 1'b1, 1'b0, 19'd307199, 8'h55);
    tick();
    n_chk++; if (bus.bram_we !== 1'b1 || bus.bram_addr !== 19'd307199 || bus.bram_din !== 8'h55) begin n_fail++; $display("FAIL range_max: got we=%b addr=%0d din=%0h expected 1/307199/55", bus.bram_we, bus.bram_addr, bus.bram_din); end
    n_chk++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL range_cnt_keep: got %0d expected 1", drop_cnt); end
    set_req(1, 1'b1, 1'b0, 19'h7FFFF, 8'hEE);
    for (int k = 0; k < 300; k++) begin
      tick();
      if (bus.bram_we !== 1'b0) range_bad++;
      if (k == 99) begin
        n_chk++; if (drop_cnt !== 8'd101) begin n_fail++; $display("FAIL range_cnt101: got %0d expected 101", drop_cnt); end
      end
    end
    n_chk++; if (range_bad !== 0) begin n_fail++; $display("FAIL range_no_write: got %0d writes expected 0", range_bad); end
    n_chk++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL range_sat: got %0d expected 255", drop_cnt); end
  endtask

  task automatic test_idle_owner();
    apply_reset();
    set_req(1, 1'b1, 1'b0, 19'd111, 8'h01);
    tick();
    n_chk++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL idle_grant1: got %b expected 010", bus.req_ready); end
    set_req(1, 1'b0, 1'b0, 19'd111, 8'h01);
    set_req(2, 1'b1, 1'b0, 19'd222, 8'h02);
    tick();
    n_chk++; if (bus.req_ready !== 3'b100 || bus.bram_we !== 1'b0) begin n_fail++; $display("FAIL idle_grant2: got ready=%b we=%b expected 100/0", bus.req_ready, bus.bram_we); end
    tick();
    n_chk++; if (bus.bram_we !== 1'b1 || bus.bram_addr !== 19'd222) begin n_fail++; $display("FAIL idle_write2: got we=%b addr=%0d expected 1/222", bus.bram_we, bus.bram_addr); end
  endtask

  task automatic test_watchdog();
    apply_reset();
    set_req(2, 1'b1, 1'b1, 19'd100, 8'h64);
    tick();
    tick();
    set_req(2, 1'b0, 1'b1, 19'd100, 8'h64);
    set_req(0, 1'b1, 1'b0, 19'd7, 8'h03);
    repeat (1023) tick();
    n_chk++; if (bus.req_ready !== 3'b100 || lock_err !== 1'b0) begin n_fail++; $display("FAIL wd_1023_hold: got ready=%b err=%b expected 100/0", bus.req_ready, lock_err); end
    set_req(2, 1'b1, 1'b1, 19'd101, 8'h65);
    tick();
    n_chk++; if (bus.bram_we !== 1'b1 || bus.bram_addr !== 19'd101 || bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL wd_late_beat: got we=%b addr=%0d ready=%b expected 1/101/100", bus.bram_we, bus.bram_addr, bus.req_ready); end
    set_req(2, 1'b0, 1'b1, 19'd101, 8'h65);
    repeat (1023) tick();
    n_chk++; if (bus.req_ready !== 3'b100 || lock_err !== 1'b0) begin n_fail++; $display("FAIL wd_pre_fire: got ready=%b err=%b expected 100/0", bus.req_ready, lock_err); end
    tick();
    n_chk++; if (lock_err !== 1'b1 || bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL wd_fire: got err=%b ready=%b expected 1/001", lock_err, bus.req_ready); end
    tick();
    n_chk++; if (bus.bram_we !== 1'b1 || bus.bram_addr !== 19'd7) begin n_fail++; $display("FAIL wd_req0_write: got we=%b addr=%0d expected 1/7", bus.bram_we, bus.bram_addr); end
  endtask

  task automatic test_reset_mid_lock();
    set_req(0, 1'b1, 1'b1, 19'h7FFFF, 8'hF0);
    set_req(1, 1'b1, 1'b1, 19'd1, 8'hF1);
    set_req(2, 1'b1, 1'b1, 19'd2, 8'hF2);
    tick();
    set_req(0, 1'b1, 1'b1, 19'd42, 8'h2A);
    tick();
    n_chk++;
    if (busy !== 1'b1 || bus.bram_we !== 1'b1 || bus.bram_addr !== 19'd42 || lock_err !== 1'b1 || drop_cnt !== 8'd1 || bus.req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_lock_pre: got busy=%b we=%b addr=%0d err=%b drop=%0d ready=%b expected 1/1/42/1/1/001",
               busy, bus.bram_we, bus.bram_addr, lock_err, drop_cnt, bus.req_ready);
    end
    #3 reset_n = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || bus.bram_we !== 1'b0 || bus.bram_addr !== 19'd0 || bus.bram_din !== 8'd0 ||
        lock_err !== 1'b0 || drop_cnt !== 8'd0 || bus.req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_lock_async: got busy=%b we=%b addr=%0d din=%0h err=%b drop=%0d ready=%b expected all 0",
               busy, bus.bram_we, bus.bram_addr, bus.bram_din, lock_err, drop_cnt, bus.req_ready);
    end
    bus.req_lock = '0;
    #2 reset_n = 1'b1;
    tick();
    n_chk++; if (bus.req_ready !== 3'b001 || bus.bram_we !== 1'b0) begin n_fail++; $display("FAIL post_rst_grant: got ready=%b we=%b expected 001/0", bus.req_ready, bus.bram_we); end
    tick();
    n_chk++; if (bus.bram_we !== 1'b1 || bus.bram_addr !== 19'd42) begin n_fail++; $display("FAIL post_rst_write: got we=%b addr=%0d expected 1/42", bus.bram_we, bus.bram_addr); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_range();
    test_idle_owner();
    test_watchdog();
    test_reset_mid_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
